// File: rtl/key_event_gen_pkg.sv
// Shared game package: keycode constants, key-event FSM states and helpers.
// The battle and menu FSMs import the same keycode constants.
package key_event_gen_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    typedef enum logic [1:0] {
        KEV_IDLE,
        KEV_DEBOUNCE,
        KEV_HELD,
        KEV_REPEAT
    } kev_state_t;

    // Only cursor-movement keys auto-repeat; ENTER and everything else fire once.
    function automatic logic is_repeatable(input logic [7:0] code);
        return code inside {KEY_W, KEY_A, KEY_S, KEY_D};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_gen_key_out_reg.sv
// One-entry valid/ready event register; an emit that finds the slot occupied
// and not draining is discarded and flagged on dropped for one cycle.
module key_out_reg (
    input  logic       Clk,
    input  logic       clear,
    input  logic       emit,
    input  logic [7:0] emit_code,
    input  logic       emit_rpt,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] code,
    output logic       rpt,
    output logic       dropped
);

    logic xfer;
    assign xfer = valid & ready;

    always_ff @(posedge Clk) begin
        if (clear) begin
            valid   <= 1'b0;
            code    <= 8'h00;
            rpt     <= 1'b0;
            dropped <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (emit) begin
                if (!valid || xfer) begin
                    valid <= 1'b1;
                    code  <= emit_code;
                    rpt   <= emit_rpt;
                end else begin
                    dropped <= 1'b1;
                end
            end else if (xfer) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Turns the level-held USB keycode into debounced single key events with valid/ready.
// Define KEY_EVENT_REPEAT_EN to build W/A/S/D auto-repeat; otherwise one event per press.
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 500000,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000,
    parameter int CNT_W            = 25
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [7:0] keycode_raw,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_repeat,
    output logic       key_dropped
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    // Counter saturates here so a non-repeating held key can sit in HELD forever.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC) - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYC - 1);
`endif

    kev_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       cand;
    logic             clear;
    logic             changed;
    logic             emit;
    logic             emit_rpt;

    assign clear   = Reset | ~enable;
    assign changed = (state != KEV_IDLE) && (keycode_raw != cand);
    assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

    // A keycode change always wins over a same-cycle emit.
    always_comb begin
        emit = 1'b0;
        if (!changed) begin
            case (state)
                KEV_DEBOUNCE: emit = (cnt == DEB_LAST);
`ifdef KEY_EVENT_REPEAT_EN
                KEV_HELD:     emit = (cnt == DLY_LAST) && is_repeatable(cand);
                KEV_REPEAT:   emit = (cnt == RATE_LAST);
`endif
                default:      emit = 1'b0;
            endcase
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    assign emit_rpt = (state != KEV_DEBOUNCE);
`else
    assign emit_rpt = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (clear) begin
            state <= KEV_IDLE;
            cnt   <= '0;
            cand  <= KEY_NONE;
        end else if (changed || state == KEV_IDLE) begin
            cand  <= keycode_raw;
            cnt   <= '0;
            state <= (keycode_raw == KEY_NONE) ? KEV_IDLE : KEV_DEBOUNCE;
        end else begin
            case (state)
                KEV_DEBOUNCE: begin
                    if (cnt == DEB_LAST) begin
                        state <= KEV_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`ifdef KEY_EVENT_REPEAT_EN
                KEV_HELD: begin
                    if (emit) begin
                        state <= KEV_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                KEV_REPEAT: cnt <= emit ? '0 : cnt_inc;
`endif
                default: cnt <= cnt_inc;
            endcase
        end
    end

    key_out_reg u_out (
        .Clk       (Clk),
        .clear     (clear),
        .emit      (emit),
        .emit_code (cand),
        .emit_rpt  (emit_rpt),
        .ready     (key_ready),
        .valid     (key_valid),
        .code      (key_code),
        .rpt       (key_repeat),
        .dropped   (key_dropped)
    );

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios plus random key streams
// compared cycle by cycle against a run-length based event model.
module tb_key_event_gen;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] keycode_raw = 8'h00;
    logic       key_ready = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_repeat;
    logic       key_dropped;

    key_event_gen #(
        .DEBOUNCE_CYC     (DEB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR),
        .CNT_W            (25)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .enable      (enable),
        .keycode_raw (keycode_raw),
        .key_ready   (key_ready),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_repeat  (key_repeat),
        .key_dropped (key_dropped)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int dut_xfers = 0;
    int dut_drops = 0;

    // Reference: events follow from how many consecutive enabled edges saw the same key.
    int         run = 0;
    logic [7:0] prev_raw = 8'h00;
    bit         m_valid = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_rpt = 0;
    bit         m_drop = 0;

    logic [7:0] keys [7] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h28, 8'h10, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit rep_key(input logic [7:0] k);
        return (k == 8'h1A) || (k == 8'h04) || (k == 8'h16) || (k == 8'h07);
    endfunction

    task automatic step();
        bit clr;
        bit ev;
        bit evr;
        bit xfer;
        if (key_valid && key_ready) dut_xfers++;
        @(posedge Clk);
        clr = Reset || !enable;
        ev  = 0;
        evr = 0;
        if (clr || keycode_raw == 8'h00) begin
            run = 0;
        end else begin
            run = (run > 0 && keycode_raw == prev_raw) ? run + 1 : 1;
            if (run == DEB + 1) begin
                ev = 1;
            end else if (REP_EN && rep_key(keycode_raw) && run >= DEB + 1 + RD &&
                         (run - (DEB + 1 + RD)) % RR == 0) begin
                ev  = 1;
                evr = 1;
            end
        end
        prev_raw = keycode_raw;
        xfer = m_valid && key_ready;
        if (clr) begin
            m_valid = 0; m_code = 8'h00; m_rpt = 0; m_drop = 0;
        end else begin
            m_drop = 0;
            if (ev) begin
                if (!m_valid || xfer) begin
                    m_valid = 1; m_code = keycode_raw; m_rpt = evr;
                end else begin
                    m_drop = 1;
                end
            end else if (xfer) begin
                m_valid = 0;
            end
        end
        @(negedge Clk);
        if (key_dropped) dut_drops++;
        chk("valid", key_valid, m_valid);
        chk("dropped", key_dropped, m_drop);
        if (m_valid || clr) begin
            chk("code", key_code, m_code);
            chk("repeat", key_repeat, m_rpt);
        end
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        keycode_raw = k;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        dut_xfers = 0;
        dut_drops = 0;
    endtask

    initial begin
        int len;
        int ki;
        bit en_off;

        keycode_raw = 8'h00;
        key_ready = 1'b1;
        do_reset();
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_repeat", key_repeat, 0);
        chk("rst_dropped", key_dropped, 0);

        // ENTER held: exactly one event
        hold(8'h28, 50);
        hold(8'h00, 3);
        chk("enter_events", dut_xfers, 1);

        // W held 25 edges: first event plus repeats when built
        do_reset();
        hold(8'h1A, 25);
        hold(8'h00, 3);
        chk("w_events", dut_xfers, REP_EN ? 5 : 1);

        // Short presses and bouncing never produce an event
        do_reset();
        hold(8'h04, 2);
        hold(8'h00, 2);
        for (int i = 0; i < 5; i++) begin
            hold(8'h04, 2);
            hold(8'h00, 2);
        end
        chk("glitch_events", dut_xfers, 0);
        chk("glitch_valid", key_valid, 0);

        // Backpressure: S pending, D dropped, then one transfer of S
        do_reset();
        key_ready = 1'b0;
        hold(8'h16, 6);
        hold(8'h00, 2);
        hold(8'h07, 6);
        hold(8'h00, 2);
        chk("bp_drops", dut_drops, 1);
        chk("bp_code", key_code, 8'h16);
        key_ready = 1'b1;
        step();
        step();
        chk("bp_xfers", dut_xfers, 1);
        chk("bp_valid_after", key_valid, 0);

        // Direct switch S -> D without release
        do_reset();
        hold(8'h16, 8);
        hold(8'h07, 8);
        hold(8'h00, 2);
        chk("switch_events", dut_xfers, 2);

        // Reset mid-debounce restarts debouncing
        do_reset();
        hold(8'h1A, 2);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_mid_valid", key_valid, 0);
        hold(8'h1A, 6);
        hold(8'h00, 2);
        chk("rst_mid_events", dut_xfers, 1);

        // Reset with an event pending clears it
        do_reset();
        key_ready = 1'b0;
        hold(8'h28, 6);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_pend_valid", key_valid, 0);
        hold(8'h28, 3);
        hold(8'h00, 2);
        key_ready = 1'b1;

        // enable low flushes; held key re-debounces after enable returns
        do_reset();
        hold(8'h28, 7);
        enable = 1'b0;
        hold(8'h28, 2);
        chk("en_low_valid", key_valid, 0);
        enable = 1'b1;
        hold(8'h28, 7);
        hold(8'h00, 2);
        chk("en_events", dut_xfers, 2);

        // Random key streams with random backpressure, enable drops and resets
        for (int s = 0; s < 80; s++) begin
            len = $urandom_range(1, 24);
            ki = $urandom_range(0, 6);
            en_off = ($urandom_range(0, 9) == 0);
            for (int c = 0; c < len; c++) begin
                keycode_raw = keys[ki];
                key_ready = ($urandom_range(0, 3) != 0);
                enable = !(en_off && c < 3);
                Reset = ($urandom_range(0, 99) == 0);
                step();
            end
        end
        Reset = 1'b0;
        enable = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Producer side of the keycode interface consumed by the battle and menu FSMs.
- Converts the level-held USB keycode into single, debounced key events with valid/ready handshake, so a held key never races a consumer FSM through several states.
- Held W/A/S/D keys auto-repeat for cursor movement. ENTER and all other keys fire exactly once per press.
- Sits between the USB keyboard keycode register and the game FSMs.

Parameters:
- DEBOUNCE_CYC, 500000: cycles a nonzero keycode must stay stable before the first event (10 ms at 50 MHz).
- REPEAT_DELAY_CYC, 25000000: cycles from the first event to the first auto-repeat (500 ms).
- REPEAT_RATE_CYC, 5000000: cycles between subsequent auto-repeats (100 ms).
- CNT_W, 25: width of the shared timing counter; must hold max(all three)-1.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- enable  in  1  event generation allowed; low flushes state
- keycode_raw  in  8  current USB keycode, 0x00 = no key
- key_ready  in  1  consumer accepts the event this cycle
- key_valid  out  1  event pending
- key_code  out  8  keycode of the pending event
- key_repeat  out  1  pending event is an auto-repeat
- key_dropped  out  1  one-cycle pulse when an event is lost to backpressure

Behaviour:
- Reset: state IDLE, counter 0, cand 0. key_valid=0, key_code=0x00, key_repeat=0, key_dropped=0.
- States: IDLE, DEBOUNCE, HELD, REPEAT. A single counter cnt is cleared on every state entry.
- Change rule, applies in DEBOUNCE, HELD and REPEAT whenever keycode_raw != cand:
  - raw = 0 -> IDLE.
  - raw nonzero -> DEBOUNCE with cand = raw, cnt = 0.
  - The change rule has priority over any emit in the same cycle.
- IDLE: raw nonzero -> DEBOUNCE, cand = raw.
- DEBOUNCE: cnt++. When cnt == DEBOUNCE_CYC-1 with raw == cand -> emit(cand, repeat=0), go to HELD.
  - key_valid rises after the (DEBOUNCE_CYC+1)th consecutive rising edge that samples the same nonzero raw.
- HELD: cnt++. When cnt == REPEAT_DELAY_CYC-1 and cand is repeatable -> emit(cand, repeat=1), go to REPEAT.
  - Non-repeatable cand: stay in HELD with cnt saturated until release or change.
- REPEAT: cnt++. When cnt == REPEAT_RATE_CYC-1 -> emit(cand, repeat=1), cnt = 0.
- Repeatable set: 0x1A W, 0x04 A, 0x16 S, 0x07 D. ENTER 0x28 is never repeatable.
- Output register and handshake:
  - A transfer happens when key_valid && key_ready.
  - emit with key_valid=0, or emit in the same cycle as a transfer: load key_code/key_repeat, key_valid=1.
  - emit while key_valid=1 and no transfer: the new event is discarded, the old one is kept, key_dropped=1 for one cycle.
  - Transfer with no emit: key_valid=0 next cycle.
  - key_code and key_repeat are stable while key_valid=1 and not accepted.
- enable=0: state IDLE, cnt=0, key_valid=0, no events.
  - A key already held when enable rises must debounce afresh and then produces an event.
- Reset mid-operation overrides everything, including a pending un-accepted event.

Optional Feature:
- Macro KEY_EVENT_REPEAT_EN.
- Defined: auto-repeat as above.
- Undefined:
  - HELD never exits on timeout and the REPEAT state is not built.
  - key_repeat is tied 0.
  - Every key, W/A/S/D included, emits exactly one event per press.

Decomposition:
- Shared game package holds:
  - keycode constants KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER, KEY_NONE.
  - the kev_state_t enum.
  - function is_repeatable(logic [7:0]).
  - The battle and menu FSMs import the same keycode constants.
- One natural sub-module, key_out_reg: the one-entry valid/ready output register with drop detection. Inputs emit, code, repeat, ready; outputs valid, code, repeat, dropped.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, key_ready=1 unless stated; edges numbered from the first edge sampling the key as E1):
- ENTER 0x28 held 50 cycles -> exactly one key_valid pulse, asserted after E5, key_code=0x28, key_repeat=0, no further events until release.
- W 0x1A held 25 edges -> first event after E5 with key_repeat=0; repeats with key_repeat=1 after E15, E18, E21, E24; none after release. With macro undefined, only the E5 event.
- A 0x04 for 2 cycles then 0x00, or alternating 0x04/0x00 every 2 cycles -> no event, key_valid stays 0.
- key_ready=0; press/release S (0x16), then press/release D (0x07) -> key_valid=1 with key_code=0x16 held stable; key_dropped pulses once at D's emit; raising key_ready gives one transfer of 0x16, then key_valid=0.
- S held, then switched directly to D without 0x00 -> S event, then a D event DEBOUNCE_CYC+1 edges after the switch with key_repeat=0.
- Reset asserted mid-DEBOUNCE and with an event pending, or enable=0 -> next cycle all outputs 0; an event after release is only possible via a full fresh debounce.
